pipe_stage_skid_reg: RTL

Parametrised, elastic successor to the fixed EX/MEM pipeline register: a two-entry skid-buffered stage register with valid/ready handshake, synchronous flush and bubble insertion. It sits between any two pipeline stages (EX/MEM first, then ID/EX and MEM/WB). It carries a control field that is forced to zero whenever the stage holds no valid instruction, so a bubble can never write the register file or memory. Backpressure from the downstream stage is absorbed without a combinational ready path upstream. A saturating stall counter supports performance analysis.

---
 rtl/pipe_stage_skid_reg.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Elastic two-entry pipeline stage register (main + skid) with a valid/ready
// handshake on both sides, synchronous flush and bubble gating of the control
// field. in_ready depends on registered state only, so there is no
// combinational path from out_ready back to the upstream stage. A saturating
// counter records the cycles in which downstream stalled a valid entry.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  side-effecting control width (zeroed whenever out_valid = 0)
//   CNT_W   stall counter width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   flush      synchronous kill of held and incoming entries
//   clr_stats  synchronous clear of stall_cnt
//   in_valid   upstream holds a valid entry
//   in_ready   stage can accept an entry this cycle
//   in_ctrl    upstream control field
//   in_data    upstream payload
//   out_valid  stage presents a valid entry
//   out_ready  downstream accepts this cycle
//   out_ctrl   control field of the head entry, 0 when no entry is held
//   out_data   payload of the head entry (holds last loaded value when empty)
//   occupancy  number of entries held (0, 1, 2)
//   stall_cnt  saturating count of downstream-stall cycles
// ----------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W = 133,
    parameter int unsigned CTRL_W = 7,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding equals the number of entries held, so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush overrides every transition
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) state_nxt = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_nxt = FULL;
                    else if (!in_fire && out_fire) state_nxt = EMPTY;
                end
                FULL:    if (out_fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered state only; out_ctrl gated by valid)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        occupancy = state;
        out_ctrl  = out_valid ? main_ctrl : '0;
        out_data  = main_data;
    end

    // ------------------------------------------------------------------
    // Datapath load enables; flush suppresses all loads
    // ------------------------------------------------------------------
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            load_main_in   = in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
            load_main_skid = (state == FULL) && out_fire;
            load_skid      = (state == ONE) && in_fire && !out_fire;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall counter; clr_stats wins over increment
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
